vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48 (H_TOTAL = 800), horizontal porch/sync widths in pixels.
REQ-003 SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33 (V_TOTAL = 525), vertical widths in lines.
REQ-004 SHALL have ports: clk  in  1  pixel clock (25.175 MHz nominal), all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: x  out  10  current horizontal count, 0..H_TOTAL-1.
REQ-007 SHALL have ports: y  out  10  current vertical count, 0..V_TOTAL-1.
REQ-008 SHALL have ports: hsync  out  1  horizontal sync, active low.
REQ-009 SHALL have ports: vsync  out  1  vertical sync, active low.
REQ-010 SHALL have ports: display_on  out  1  high when (x,y) is inside the visible area.
REQ-011 SHALL have ports: next_frame  out  1  single-cycle pulse marking the start of vertical blanking.
REQ-012 SHALL have ports: frame_count  out  8  free-running frame counter.

Function
REQ-013 SHALL keep registered counters hpos (10 bit) and vpos (10 bit); x = hpos, y = vpos with zero latency.
REQ-014 SHALL increment hpos every clk; at hpos == H_TOTAL-1 it wraps to 0.
REQ-015 SHALL increment vpos only on the cycle hpos wraps; at vpos == V_TOTAL-1 coincident with the hpos wrap, vpos wraps to 0.
REQ-016 SHALL never let hpos exceed 799 or vpos exceed 524, including after reset.
REQ-017 SHALL drive display_on = (hpos < H_VISIBLE) && (vpos < V_VISIBLE), decoded combinationally from the counters.
REQ-018 SHALL drive hsync low exactly when 656 <= hpos <= 751 (H_VISIBLE+H_FRONT through +H_SYNC-1), high otherwise.
REQ-019 SHALL drive vsync low exactly when 490 <= vpos <= 491, for the whole line, high otherwise.
REQ-020 SHALL assert next_frame for exactly one clk per frame, when hpos == 0 && vpos == V_VISIBLE (480).
REQ-021 SHALL increment frame_count by 1 on the clock edge ending the next_frame cycle; wraps 255 -> 0 silently.
REQ-022 SHALL make all outputs a pure function of hpos, vpos, frame_count registers (no output-only latency stage).
REQ-023 SHALL use unsigned arithmetic; all compares against constants sized to 10 bits.

Reset
REQ-024 SHALL on rst asynchronously set hpos = 0, vpos = 0, frame_count = 0.
REQ-025 SHALL therefore present during and right after reset: x = 0, y = 0, display_on = 1, hsync = 1, vsync = 1, next_frame = 0, frame_count = 0.
REQ-026 SHALL restart counting at (0,0) on the first rising clk after rst deasserts; reset mid-line or mid-frame discards the partial frame with no next_frame pulse.

Structure
REQ-027 SHALL take all timing constants (visible, porch, sync, total for H and V) from shared package vga_timing_pkg, also used by the pattern generators (center = H_VISIBLE/2, V_VISIBLE/2).
REQ-028 SHALL instantiate one sub-module wrap_counter (parameterised width and modulus, enable in, wrap out) twice: horizontal with enable = 1, vertical with enable = horizontal wrap.
REQ-029 SHALL contain no other state; target 120-200 lines RTL including sub-module.

Verification
REQ-030 SHALL cover: release reset, run 800 clks -> x steps 0..799 then 0, y increments 0 -> 1 exactly at the wrap.
REQ-031 SHALL cover: full line -> hsync low for exactly 96 clks starting at x = 656; display_on high for exactly 640 clks per visible line.
REQ-032 SHALL cover: full frame (420000 clks) -> vsync low for exactly 1600 clks starting at (0,490); next_frame exactly one pulse at (0,480); display_on high for 307200 clks.
REQ-033 SHALL cover: run 256 frames -> frame_count returns to 0 and next_frame pulse count = 256.
REQ-034 SHALL cover: assert rst at (x=300,y=200) asynchronously -> x,y,frame_count read 0 before next clk edge; after release, timing identical to cold start.
REQ-035 SHALL cover: drive spiral_gen from this block for 3 frames -> spiral_gen rotation_offset advances exactly once per next_frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants.
// Used by the timing generator and by the pattern generators.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT
                               + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT
                               + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_CNT_W     = 10;
  localparam int VGA_FRAME_W   = 8;

  localparam int VGA_H_CENTER  = VGA_H_VISIBLE / 2;
  localparam int VGA_V_CENTER  = VGA_V_VISIBLE / 2;

  // Sizes a timing constant to the counter width so every
  // compare against hpos/vpos is 10-bit unsigned.
  function automatic logic [VGA_CNT_W-1:0] cnt_const(
    input int v
  );
    return VGA_CNT_W'(v);
  endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-N up counter with enable and a wrap strobe.
// Ports: clk, rst (async high), en, count, wrap.
module wrap_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_last;

  // >= keeps the counter bounded even from an
  // unexpected out-of-range value.
  assign at_last = (count_q >= LAST);
  assign wrap    = en && at_last;
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, syncs, blanking, frame tick.
// Ports: clk, rst, x, y, hsync, vsync, display_on, next_frame, frame_count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [VGA_CNT_W-1:0]   x,
  output logic [VGA_CNT_W-1:0]   y,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   display_on,
  output logic                   next_frame,
  output logic [VGA_FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [VGA_CNT_W-1:0] H_VIS_C =
    cnt_const(H_VISIBLE);
  localparam logic [VGA_CNT_W-1:0] H_SYN_FIRST =
    cnt_const(H_VISIBLE + H_FRONT);
  localparam logic [VGA_CNT_W-1:0] H_SYN_LAST =
    cnt_const(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VGA_CNT_W-1:0] V_VIS_C =
    cnt_const(V_VISIBLE);
  localparam logic [VGA_CNT_W-1:0] V_SYN_FIRST =
    cnt_const(V_VISIBLE + V_FRONT);
  localparam logic [VGA_CNT_W-1:0] V_SYN_LAST =
    cnt_const(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [VGA_CNT_W-1:0]   hpos;
  logic [VGA_CNT_W-1:0]   vpos;
  logic                   h_wrap;
  logic                   v_wrap_unused;
  logic [VGA_FRAME_W-1:0] frame_count_q;
  logic [VGA_FRAME_W-1:0] frame_count_d;

  wrap_counter #(
    .WIDTH   (VGA_CNT_W),
    .MODULUS (H_TOTAL)
  ) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (hpos),
    .wrap  (h_wrap)
  );

  wrap_counter #(
    .WIDTH   (VGA_CNT_W),
    .MODULUS (V_TOTAL)
  ) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (vpos),
    .wrap  (v_wrap_unused)
  );

  assign x = hpos;
  assign y = vpos;

  assign display_on = (hpos < H_VIS_C) && (vpos < V_VIS_C);

  assign hsync = !((hpos >= H_SYN_FIRST) &&
                   (hpos <= H_SYN_LAST));

  assign vsync = !((vpos >= V_SYN_FIRST) &&
                   (vpos <= V_SYN_LAST));

  // First pixel of the first blank line: once per frame,
  // and never after a reset until the raster gets there.
  assign next_frame = (hpos == '0) && (vpos == V_VIS_C);

  assign frame_count = frame_count_q;

  always_comb begin
    frame_count_d = frame_count_q;
    if (next_frame) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster
// (15 x 11) so hundreds of frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = 15;
  localparam int VT = 11;
  localparam int FRAME = HT * VT;

  logic       clk;
  logic       rst;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       next_frame;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_VISIBLE (HV),
    .H_FRONT   (HF),
    .H_SYNC    (HS),
    .H_BACK    (HB),
    .V_VISIBLE (VV),
    .V_FRONT   (VF),
    .V_SYNC    (VS),
    .V_BACK    (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .next_frame  (next_frame),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int ex;
  int ey;
  int efc;
  int nf_total;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("x", 32'(x), 32'(ex));
    check("y", 32'(y), 32'(ey));
    check("disp", 32'(display_on),
          32'((ex < HV) && (ey < VV)));
    check("hsync", 32'(hsync),
          32'(!(ex >= 10 && ex <= 12)));
    check("vsync", 32'(vsync),
          32'(!(ey >= 7 && ey <= 8)));
    check("nf", 32'(next_frame),
          32'(ex == 0 && ey == 6));
    check("fc", 32'(frame_count), 32'(efc));
  endtask

  // One clock: advance the model, then sample at negedge.
  task automatic step();
    @(posedge clk);
    if (ex == 0 && ey == 6) efc = (efc + 1) % 256;
    if (ex == HT - 1) begin
      ex = 0;
      ey = (ey == VT - 1) ? 0 : ey + 1;
    end else begin
      ex = ex + 1;
    end
    @(negedge clk);
    check_all();
    if (next_frame === 1'b1) nf_total++;
  endtask

  task automatic run_line();
    int hs_lo;
    int dsp;
    hs_lo = 0;
    dsp = 0;
    for (int i = 0; i < HT; i++) begin
      step();
      if (hsync === 1'b0) hs_lo++;
      if (display_on === 1'b1) dsp++;
    end
    check("line_hs_lo", 32'(hs_lo), 32'd3);
    check("line_disp", 32'(dsp), 32'd8);
  endtask

  task automatic run_frame();
    int hs_lo;
    int vs_lo;
    int dsp;
    int nfs;
    hs_lo = 0;
    vs_lo = 0;
    dsp = 0;
    nfs = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (hsync === 1'b0) hs_lo++;
      if (vsync === 1'b0) vs_lo++;
      if (display_on === 1'b1) dsp++;
      if (next_frame === 1'b1) nfs++;
    end
    check("frm_hs_lo", 32'(hs_lo), 32'd33);
    check("frm_vs_lo", 32'(vs_lo), 32'd30);
    check("frm_disp", 32'(dsp), 32'd48);
    check("frm_nf", 32'(nfs), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    nf_total = 0;
    ex = 0;
    ey = 0;
    efc = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    // first line: y steps to 1 exactly at the wrap
    for (int i = 0; i < HT - 1; i++) step();
    check("eol_x", 32'(x), 32'd14);
    check("eol_y", 32'(y), 32'd0);
    step();
    check("wrap_x", 32'(x), 32'd0);
    check("wrap_y", 32'(y), 32'd1);

    run_line();

    // cumulative from release: 256 frame ticks wrap fc
    for (int f = 0; f < 256; f++) run_frame();
    check("nf_256", 32'(nf_total), 32'd256);
    check("fc_wrap", 32'(frame_count), 32'd0);

    run_frame();
    check("fc_one", 32'(frame_count), 32'd1);

    // seek mid-frame and reset asynchronously
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (ex == 7 && ey == 4) break;
      step();
    end
    check("seek_x", 32'(x), 32'd7);
    check("seek_y", 32'(y), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_x", 32'(x), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    check("arst_fc", 32'(frame_count), 32'd0);
    check("arst_disp", 32'(display_on), 32'd1);
    check("arst_hs", 32'(hsync), 32'd1);
    check("arst_vs", 32'(vsync), 32'd1);
    check("arst_nf", 32'(next_frame), 32'd0);
    @(negedge clk);
    ex = 0;
    ey = 0;
    efc = 0;
    check_all();
    rst = 1'b0;

    // after a warm reset the raster matches a cold start
    for (int i = 0; i < HT; i++) step();
    check("warm_y", 32'(y), 32'd1);
    run_frame();
    check("warm_fc", 32'(frame_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
